// File: rtl/rover_pkg.sv
// rover_pkg: shared FSM states, orientation constants and tangent thresholds for the heading block.
package rover_pkg;

    typedef enum logic [1:0] {IDLE, DIFF, CMP, MAP} state_t;

    localparam int ORIENT_STEPS = 24;
    localparam int QUAD_STEPS   = 6;
    localparam int TAN_W        = 11;

    // round(tan(7.5 + 15*i deg) * 256): sector boundaries within one quadrant
    localparam logic [TAN_W-1:0] TAN_T [QUAD_STEPS] = '{
        11'd34, 11'd106, 11'd196, 11'd334, 11'd618, 11'd1945
    };

endpackage

// File: rtl/rover_heading_if.sv
// rover_heading_if: request/result bundle between the position tracker and the heading block.
interface rover_heading_if #(parameter int COORD_W = 12);

    logic                      start;
    logic signed [COORD_W-1:0] x0;
    logic signed [COORD_W-1:0] y0;
    logic signed [COORD_W-1:0] x1;
    logic signed [COORD_W-1:0] y1;
    logic                      busy;
    logic                      done;
    logic [4:0]                orientation;
    logic signed [COORD_W-1:0] center_x;
    logic signed [COORD_W-1:0] center_y;
    logic                      still;

    modport master (
        output start, x0, y0, x1, y1,
        input  busy, done, orientation, center_x, center_y, still
    );

    modport slave (
        input  start, x0, y0, x1, y1,
        output busy, done, orientation, center_x, center_y, still
    );

endinterface

// File: rtl/tan_threshold_rom.sv
// tan_threshold_rom: combinational lookup of the per-sector tangent threshold.
module tan_threshold_rom
    import rover_pkg::*;
(
    input  logic [2:0]       idx,
    output logic [TAN_W-1:0] t
);

    assign t = (idx < 3'(QUAD_STEPS)) ? TAN_T[idx] : '0;

endmodule

// File: rtl/rover_heading.sv
// rover_heading: quantizes the heading between two fixes into 24 sectors with a fixed 9-cycle
// iterative tangent comparison, and latches the sprite center.
module rover_heading
    import rover_pkg::*;
#(
    parameter int COORD_W = 12,
    parameter int FRAC    = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    rover_heading_if.slave bus
);

    localparam int CMP_W = 24;
    localparam logic [4:0] HALF = 5'(ORIENT_STEPS / 2);

    state_t                    state;
    logic signed [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic signed [COORD_W:0]   dx, dy;
    logic [COORD_W-1:0]        ax, ay;
    logic                      sx, sy;
    logic [2:0]                i, k;
    logic [TAN_W-1:0]          t;
    logic                      hit;
    logic [4:0]                o_next;

    tan_threshold_rom u_rom (.idx(i), .t(t));

    assign dx  = {x1_q[COORD_W-1], x1_q} - {x0_q[COORD_W-1], x0_q};
    assign dy  = {y1_q[COORD_W-1], y1_q} - {y0_q[COORD_W-1], y0_q};
    // strict compare: a tie stays in the sector nearer the x axis
    assign hit = (CMP_W'(ay) << FRAC) > (CMP_W'(ax) * CMP_W'(t));
    assign o_next = sx ? (sy ? HALF + 5'(k) : HALF - 5'(k))
                       : (sy ? ((k == 3'd0) ? 5'd0 : 5'(ORIENT_STEPS) - 5'(k)) : 5'(k));
    assign bus.busy = state != IDLE;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            x0_q            <= '0;
            y0_q            <= '0;
            x1_q            <= '0;
            y1_q            <= '0;
            ax              <= '0;
            ay              <= '0;
            sx              <= 1'b0;
            sy              <= 1'b0;
            i               <= '0;
            k               <= '0;
            bus.done        <= 1'b0;
            bus.orientation <= '0;
            bus.center_x    <= '0;
            bus.center_y    <= '0;
            bus.still       <= 1'b1;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    x0_q  <= bus.x0;
                    y0_q  <= bus.y0;
                    x1_q  <= bus.x1;
                    y1_q  <= bus.y1;
                    state <= DIFF;
                end
                DIFF: begin
                    sx    <= dx[COORD_W];
                    sy    <= dy[COORD_W];
                    ax    <= dx[COORD_W] ? COORD_W'(-dx) : dx[COORD_W-1:0];
                    ay    <= dy[COORD_W] ? COORD_W'(-dy) : dy[COORD_W-1:0];
                    i     <= '0;
                    k     <= '0;
                    state <= CMP;
                end
                CMP: begin
                    if (hit) k <= k + 3'd1;
                    i <= i + 3'd1;
                    if (i == 3'(QUAD_STEPS - 1)) state <= MAP;
                end
                MAP: begin
                    if (ax == '0 && ay == '0) begin
                        bus.still <= 1'b1;
                    end else begin
                        bus.still       <= 1'b0;
                        bus.orientation <= o_next;
                    end
                    bus.center_x <= x1_q;
                    bus.center_y <= y1_q;
                    bus.done     <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
